// File: rtl/data_stack.sv
// -----------------------------------------------------------------------------
// data_stack
//   LIFO data stack with a dedicated top-of-stack register and a DEPTH-1 entry
//   array holding the entries underneath it. Push and pop may be asserted in
//   the same cycle to replace the top entry. Overflow and underflow are sticky
//   flags that only clr_err clears.
//
// Ports
//   CLK         in   1              rising-edge clock
//   reset       in   1              asynchronous active-low reset
//   push        in   1              place write_data on top of stack
//   pop         in   1              discard current top entry
//   write_data  in   WIDTH          value to push
//   clr_err     in   1              synchronous clear of overflow/underflow
//   read_data   out  WIDTH          registered top of stack, 0 when empty
//   count       out  log2(DEPTH)+1  number of valid entries
//   empty       out  1              count == 0
//   full        out  1              count == DEPTH
//   overflow    out  1              sticky: push while full
//   underflow   out  1              sticky: pop while empty
// -----------------------------------------------------------------------------
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         read_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Top-of-stack register plus the array of entries below it. Array slot k
  // holds the (k+1)-th entry from the bottom, so with count_q valid entries
  // the entry directly below the top sits at count_q-2.
  logic [WIDTH-1:0] top_q, top_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH-1];

  logic             wr_en_s;
  logic [CW-1:0]    wr_idx_s;
  logic [CW-1:0]    rd_idx_s;
  logic [AW-1:0]    wr_addr_s;
  logic [AW-1:0]    rd_addr_s;

  // Array addresses derived from the current count; only used when the
  // count range guarantees they fall inside 0..DEPTH-2.
  always_comb begin
    wr_idx_s  = count_q - CNT_ONE;
    rd_idx_s  = count_q - CNT_TWO;
    wr_addr_s = wr_idx_s[AW-1:0];
    rd_addr_s = rd_idx_s[AW-1:0];
  end

  // Next-state logic for the top register, count, status and error flags.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_en_s = 1'b0;
    // Clear first so that an error raised in the same cycle wins.
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;

    case ({push, pop})
      2'b10: begin
        if (full_q) begin
          ovf_d = 1'b1;
        end else begin
          // Old top moves into the array only if there was a valid top.
          wr_en_s = !empty_q;
          top_d   = write_data;
          count_d = count_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (empty_q) begin
          unf_d = 1'b1;
        end else if (count_q == CNT_ONE) begin
          top_d   = {WIDTH{1'b0}};
          count_d = CNT_ZERO;
        end else begin
          top_d   = mem_q[rd_addr_s];
          count_d = count_q - CNT_ONE;
        end
      end
      2'b11: begin
        // Replace top; on an empty stack this degenerates to a plain push.
        top_d = write_data;
        if (empty_q) begin
          count_d = CNT_ONE;
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        top_d   = top_q;
        count_d = count_q;
      end
    endcase

    empty_d = (count_d == CNT_ZERO);
    full_d  = (count_d == CNT_FULL);
  end

  // State registers; empty/full are registered alongside count.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      top_q   <= {WIDTH{1'b0}};
      count_q <= CNT_ZERO;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Array storage; never reset because stale slots are unreachable once
  // count is cleared.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= top_q;
    end
  end

  assign read_data = top_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// -----------------------------------------------------------------------------
// tb_data_stack
//   Directed self-checking bench for data_stack (WIDTH=16, DEPTH=16).
//   Inputs change on the falling edge; outputs are sampled 1 time unit after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic             CLK;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] write_data;
  logic             clr_err;
  logic [WIDTH-1:0] read_data;
  logic [4:0]       count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int checks;
  int errors;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .write_data (write_data),
    .clr_err    (clr_err),
    .read_data  (read_data),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One clocked operation: drive on the falling edge, sample just after rise.
  task automatic op(input logic p, input logic q, input logic [15:0] d, input logic c);
    @(negedge CLK);
    push       = p;
    pop        = q;
    write_data = d;
    clr_err    = c;
    @(posedge CLK);
    #1;
    push       = 1'b0;
    pop        = 1'b0;
    clr_err    = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL reset_rd got %h exp 0000", read_data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_basic;
    op(1'b1, 1'b0, 16'h1111, 1'b0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_notempty got %b exp 0", empty); end
    op(1'b1, 1'b0, 16'h2222, 1'b0);
    op(1'b1, 1'b0, 16'h3333, 1'b0);
    checks++; if (read_data !== 16'h3333) begin errors++; $display("FAIL basic_top got %h exp 3333", read_data); end
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", count); end
    op(1'b0, 1'b0, 16'h0000, 1'b0);
    checks++; if (read_data !== 16'h3333 || count !== 5'd3) begin errors++; $display("FAIL basic_hold got %h/%0d exp 3333/3", read_data, count); end
    op(1'b0, 1'b1, 16'h0000, 1'b0);
    checks++; if (read_data !== 16'h2222) begin errors++; $display("FAIL basic_pop1 got %h exp 2222", read_data); end
    op(1'b0, 1'b1, 16'h0000, 1'b0);
    checks++; if (read_data !== 16'h1111) begin errors++; $display("FAIL basic_pop2 got %h exp 1111", read_data); end
    op(1'b0, 1'b1, 16'h0000, 1'b0);
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL basic_pop3 got %h exp 0000", read_data); end
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL basic_empty got %b/%0d exp 1/0", empty, count); end
  endtask

  task automatic test_full;
    for (int i = 1; i <= DEPTH; i++) begin
      op(1'b1, 1'b0, 16'(i), 1'b0);
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    op(1'b1, 1'b0, 16'hFFFF, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf got %b exp 1", overflow); end
    checks++; if (read_data !== 16'h0010) begin errors++; $display("FAIL full_top got %h exp 0010", read_data); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", count); end
    // Replace top while full: no overflow change beyond the sticky one.
    op(1'b0, 1'b0, 16'h0000, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_clr got %b exp 0", overflow); end
    op(1'b1, 1'b1, 16'h0BEE, 1'b0);
    checks++; if (read_data !== 16'h0BEE || count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL full_pp got %h/%0d/%b exp 0bee/16/0", read_data, count, overflow); end
    // Drain: entries below the top come back 0x000F down to 0x0001.
    for (int i = DEPTH - 1; i >= 1; i--) begin
      op(1'b0, 1'b1, 16'h0000, 1'b0);
      checks++; if (read_data !== 16'(i) || count !== 5'(i)) begin errors++; $display("FAIL full_drain got %h/%0d exp %h/%0d", read_data, count, 16'(i), i); end
    end
    op(1'b0, 1'b1, 16'h0000, 1'b0);
    checks++; if (empty !== 1'b1 || read_data !== 16'h0000 || underflow !== 1'b0) begin errors++; $display("FAIL full_last got %b/%h/%b exp 1/0000/0", empty, read_data, underflow); end
  endtask

  task automatic test_underflow;
    op(1'b0, 1'b1, 16'h0000, 1'b0);
    checks++; if (underflow !== 1'b1 || read_data !== 16'h0000) begin errors++; $display("FAIL unf_set got %b/%h exp 1/0000", underflow, read_data); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL unf_count got %0d exp 0", count); end
    op(1'b0, 1'b0, 16'h0000, 1'b1);
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL unf_clr got %b%b exp 00", overflow, underflow); end
    op(1'b0, 1'b1, 16'h0000, 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_prio got %b exp 1", underflow); end
    op(1'b0, 1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_back_to_back;
    op(1'b1, 1'b0, 16'h00AA, 1'b0);
    op(1'b1, 1'b0, 16'h00BB, 1'b0);
    op(1'b1, 1'b1, 16'h00CC, 1'b0);
    checks++; if (read_data !== 16'h00CC || count !== 5'd2) begin errors++; $display("FAIL b2b_replace got %h/%0d exp 00cc/2", read_data, count); end
    op(1'b0, 1'b1, 16'h0000, 1'b0);
    checks++; if (read_data !== 16'h00AA || count !== 5'd1) begin errors++; $display("FAIL b2b_pop got %h/%0d exp 00aa/1", read_data, count); end
    op(1'b0, 1'b1, 16'h0000, 1'b0);
    // Push and pop on an empty stack acts as a plain push.
    op(1'b1, 1'b1, 16'h1234, 1'b0);
    checks++; if (read_data !== 16'h1234 || count !== 5'd1 || underflow !== 1'b0) begin errors++; $display("FAIL b2b_empty got %h/%0d/%b exp 1234/1/0", read_data, count, underflow); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
    end
    @(negedge CLK);
    push       = 1'b1;
    write_data = 16'h0DEA;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (count !== 5'd0 || read_data !== 16'h0000 || empty !== 1'b1) begin errors++; $display("FAIL async_rst got %0d/%h/%b exp 0/0000/1", count, read_data, empty); end
    @(posedge CLK);
    #1;
    push = 1'b0;
    checks++; if (count !== 5'd0 || read_data !== 16'h0000) begin errors++; $display("FAIL async_hold got %0d/%h exp 0/0000", count, read_data); end
    @(negedge CLK);
    reset = 1'b1;
    op(1'b1, 1'b0, 16'h0042, 1'b0);
    checks++; if (count !== 5'd1 || read_data !== 16'h0042) begin errors++; $display("FAIL async_push got %0d/%h exp 1/0042", count, read_data); end
    op(1'b0, 1'b1, 16'h0000, 1'b0);
    checks++; if (empty !== 1'b1 || read_data !== 16'h0000 || underflow !== 1'b0) begin errors++; $display("FAIL async_pop got %b/%h/%b exp 1/0000/0", empty, read_data, underflow); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    push       = 1'b0;
    pop        = 1'b0;
    write_data = 16'h0000;
    clr_err    = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
